// File: rtl/mem_req_initiator.sv
// mem_req_initiator: processor-side initiator for one port of the shared
// memory subsystem. Core load/store commands are queued in a small FIFO and
// issued one at a time as a memory transaction held until processor_resp.
// Each command returns exactly one response pulse, carrying load data or a
// timeout error, in command order.
module mem_req_initiator #(
    parameter int DATA_SIZE      = 2,
    parameter int ADDR_WIDTH     = 14,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int DW            = DATA_SIZE * 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    // core command interface
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DW-1:0]         cmd_wdata,
    // core response interface
    output logic                  rsp_valid,
    output logic                  rsp_write,
    output logic [DW-1:0]         rsp_rdata,
    output logic                  rsp_error,
    // memory interface
    output logic                  processor_req,
    output logic                  mem_read_req,
    output logic                  mem_write_req,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DW-1:0]         mem_write_data,
    input  logic [DW-1:0]         mem_read_data,
    input  logic                  processor_resp
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 1 + ADDR_WIDTH + DW;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMO_ONE  = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 32'sd1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // command FIFO storage: {write, addr, wdata} per entry
    logic [EW-1:0]         fifo_mem_r [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic [CW-1:0]         count_next_s;
    logic                  ready_r;
    logic                  push_s;
    logic                  pop_s;
    logic                  empty_s;

    logic [EW-1:0]         head_s;
    logic                  head_write_s;
    logic [ADDR_WIDTH-1:0] head_addr_s;
    logic [DW-1:0]         head_wdata_s;

    state_t                state_r;
    logic [TW-1:0]         tmo_cnt_r;

    // cmd_ready comes straight from a register, so it never depends on cmd_valid
    assign cmd_ready = ready_r;

    assign empty_s = (count_r == {CW{1'b0}});
    assign push_s  = cmd_valid && ready_r;
    assign pop_s   = (state_r == ST_IDLE) && !empty_s;

    assign head_s       = fifo_mem_r[rd_ptr_r];
    assign head_write_s = head_s[EW-1];
    assign head_addr_s  = head_s[EW-2 -: ADDR_WIDTH];
    assign head_wdata_s = head_s[DW-1:0];

    // next FIFO occupancy from this cycle's push/pop
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage, power-of-two wrapping pointers, occupancy and ready flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            ready_r  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= {EW{1'b0}};
            end
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= {cmd_write, cmd_addr, cmd_wdata};
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
            ready_r <= (count_next_s != CNT_FULL);
        end
    end

    // transaction FSM with registered memory and response outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_IDLE;
            tmo_cnt_r      <= {TW{1'b0}};
            processor_req  <= 1'b0;
            mem_read_req   <= 1'b0;
            mem_write_req  <= 1'b0;
            addr           <= {ADDR_WIDTH{1'b0}};
            mem_write_data <= {DW{1'b0}};
            rsp_valid      <= 1'b0;
            rsp_write      <= 1'b0;
            rsp_rdata      <= {DW{1'b0}};
            rsp_error      <= 1'b0;
        end else begin
            // response fields are only non-zero during the single pulse cycle
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= {DW{1'b0}};
            rsp_error <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    tmo_cnt_r <= {TW{1'b0}};
                    if (pop_s) begin
                        processor_req  <= 1'b1;
                        mem_read_req   <= !head_write_s;
                        mem_write_req  <= head_write_s;
                        addr           <= head_addr_s;
                        mem_write_data <= head_write_s ? head_wdata_s : {DW{1'b0}};
                        state_r        <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
                    // a response on the final allowed cycle still completes normally
                    if (processor_resp) begin
                        rsp_valid      <= 1'b1;
                        rsp_write      <= mem_write_req;
                        rsp_rdata      <= mem_write_req ? {DW{1'b0}} : mem_read_data;
                        processor_req  <= 1'b0;
                        mem_read_req   <= 1'b0;
                        mem_write_req  <= 1'b0;
                        addr           <= {ADDR_WIDTH{1'b0}};
                        mem_write_data <= {DW{1'b0}};
                        state_r        <= ST_RELEASE;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        rsp_valid      <= 1'b1;
                        rsp_write      <= mem_write_req;
                        rsp_error      <= 1'b1;
                        processor_req  <= 1'b0;
                        mem_read_req   <= 1'b0;
                        mem_write_req  <= 1'b0;
                        addr           <= {ADDR_WIDTH{1'b0}};
                        mem_write_data <= {DW{1'b0}};
                        state_r        <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    // wait out any lingering resp level so it cannot complete the next command
                    if (!processor_resp) begin
                        tmo_cnt_r <= {TW{1'b0}};
                        state_r   <= ST_IDLE;
                    end
                end

                default: begin
                    tmo_cnt_r      <= {TW{1'b0}};
                    processor_req  <= 1'b0;
                    mem_read_req   <= 1'b0;
                    mem_write_req  <= 1'b0;
                    addr           <= {ADDR_WIDTH{1'b0}};
                    mem_write_data <= {DW{1'b0}};
                    state_r        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_initiator.sv
// Directed testbench for mem_req_initiator: store, load, FIFO fill and
// ordering, resp held in RELEASE, timeout, resp on the final cycle, and
// asynchronous reset in the middle of a transaction.
module tb_mem_req_initiator;

    localparam int DW = 16;
    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic          processor_req;
    logic          mem_read_req;
    logic          mem_write_req;
    logic [AW-1:0] addr;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_read_data = '0;
    logic          processor_resp = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    mem_req_initiator dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_addr       (cmd_addr),
        .cmd_wdata      (cmd_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_write      (rsp_write),
        .rsp_rdata      (rsp_rdata),
        .rsp_error      (rsp_error),
        .processor_req  (processor_req),
        .mem_read_req   (mem_read_req),
        .mem_write_req  (mem_write_req),
        .addr           (addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .processor_resp (processor_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!processor_req && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req_seen"}, processor_req, 1);
    endtask

    task automatic serve(input string tag, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW-1:0] rd, input int hold);
        wait_req(tag);
        chk({tag, "_wr_req"}, mem_write_req, w);
        chk({tag, "_rd_req"}, mem_read_req, !w);
        chk({tag, "_addr"}, addr, a);
        chk({tag, "_wdata"}, mem_write_data, w ? wd : 16'h0000);
        processor_resp = 1'b1;
        mem_read_data  = rd;
        tick();
        chk({tag, "_rsp_valid"}, rsp_valid, 1);
        chk({tag, "_rsp_write"}, rsp_write, w);
        chk({tag, "_rsp_rdata"}, rsp_rdata, w ? 16'h0000 : rd);
        chk({tag, "_rsp_error"}, rsp_error, 0);
        chk({tag, "_req_drop"}, processor_req, 0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold_req"}, processor_req, 0);
            chk({tag, "_hold_rsp"}, rsp_valid, 0);
        end
        processor_resp = 1'b0;
        mem_read_data  = '0;
    endtask

    // bus invariants checked every cycle outside reset
    always @(negedge clk) begin
        if (reset_n) begin
            chk("inv_rd_wr_excl", mem_read_req && mem_write_req, 0);
            chk("inv_qual_needs_req", (mem_read_req || mem_write_req) && !processor_req, 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          cw [5];
        logic [AW-1:0] ca [5];
        logic [DW-1:0] cd [5];
        logic [DW-1:0] cr [5];
        int            n;
        int            lost;

        // reset state
        #1 reset_n = 1'b0;
        #1;
        chk("rst_req", processor_req, 0);
        chk("rst_rd", mem_read_req, 0);
        chk("rst_wr", mem_write_req, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_ready", cmd_ready, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("rel_ready", cmd_ready, 1);
        chk("rel_req", processor_req, 0);

        // single store, resp 3 cycles after req
        push(1'b1, 14'h0010, 16'hBEEF);
        chk("st_latency", processor_req, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_req", processor_req, 1);
            chk("st_wr_req", mem_write_req, 1);
            chk("st_rd_req", mem_read_req, 0);
            chk("st_addr", addr, 14'h0010);
            chk("st_wdata", mem_write_data, 16'hBEEF);
            chk("st_no_rsp", rsp_valid, 0);
            if (i == 2) processor_resp = 1'b1;
        end
        tick();
        chk("st_rsp_valid", rsp_valid, 1);
        chk("st_rsp_write", rsp_write, 1);
        chk("st_rsp_rdata", rsp_rdata, 0);
        chk("st_rsp_error", rsp_error, 0);
        chk("st_rel_req", processor_req, 0);
        chk("st_rel_addr", addr, 0);
        chk("st_rel_wdata", mem_write_data, 0);
        processor_resp = 1'b0;
        tick();
        chk("st_pulse_end", rsp_valid, 0);
        chk("st_write_clr", rsp_write, 0);

        // load, store data must not leak onto the bus
        push(1'b0, 14'h0005, 16'hABCD);
        serve("ld", 1'b0, 14'h0005, 16'h0000, 16'h0006, 0);
        tick();
        chk("ld_pulse_end", rsp_valid, 0);
        chk("ld_rdata_clr", rsp_rdata, 0);

        // five back-to-back commands, FIFO fills, responses in order
        cw[0] = 1'b1; ca[0] = 14'h0100; cd[0] = 16'h1111; cr[0] = 16'h0000;
        cw[1] = 1'b0; ca[1] = 14'h0101; cd[1] = 16'h5555; cr[1] = 16'h2222;
        cw[2] = 1'b1; ca[2] = 14'h0102; cd[2] = 16'h3333; cr[2] = 16'h0000;
        cw[3] = 1'b0; ca[3] = 14'h0103; cd[3] = 16'h5555; cr[3] = 16'h4444;
        cw[4] = 1'b0; ca[4] = 14'h3FFF; cd[4] = 16'h5555; cr[4] = 16'hFFFF;
        for (int k = 0; k < 5; k++) begin
            chk("b2b_ready", cmd_ready, 1);
            cmd_valid = 1'b1;
            cmd_write = cw[k];
            cmd_addr  = ca[k];
            cmd_wdata = cd[k];
            tick();
        end
        cmd_valid = 1'b0;
        chk("b2b_full", cmd_ready, 0);
        tick();
        chk("b2b_full_hold", cmd_ready, 0);
        serve("b2b0", cw[0], ca[0], cd[0], cr[0], 2);
        for (int k = 1; k < 5; k++) begin
            serve($sformatf("b2b%0d", k), cw[k], ca[k], cd[k], cr[k], 0);
        end
        tick();
        chk("b2b_drained", cmd_ready, 1);

        // timeout on a load, then the queued store issues
        push(1'b0, 14'h0020, 16'h0000);
        push(1'b1, 14'h0021, 16'h7777);
        mem_read_data = 16'hDEAD;
        n = 0;
        while (processor_req && n < 200) begin
            n++;
            tick();
        end
        chk("to_req_cycles", n, 64);
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_error", rsp_error, 1);
        chk("to_rsp_rdata", rsp_rdata, 0);
        chk("to_rsp_write", rsp_write, 0);
        tick();
        chk("to_pulse_end", rsp_valid, 0);
        chk("to_error_clr", rsp_error, 0);
        mem_read_data = '0;
        serve("to_next", 1'b1, 14'h0021, 16'h7777, 16'h0000, 0);

        // resp arriving on the 64th REQ cycle wins over timeout
        push(1'b0, 14'h0030, 16'h0000);
        wait_req("rto");
        lost = 0;
        for (int i = 1; i < 64; i++) begin
            tick();
            if (!processor_req) lost++;
        end
        chk("rto_req_held", lost, 0);
        processor_resp = 1'b1;
        mem_read_data  = 16'h1234;
        tick();
        chk("rto_rsp_valid", rsp_valid, 1);
        chk("rto_rsp_error", rsp_error, 0);
        chk("rto_rsp_rdata", rsp_rdata, 16'h1234);
        processor_resp = 1'b0;
        mem_read_data  = '0;

        // asynchronous reset mid-REQ with two commands queued
        push(1'b1, 14'h0040, 16'h0001);
        push(1'b0, 14'h0041, 16'h0000);
        push(1'b1, 14'h0042, 16'h0002);
        wait_req("rmid");
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("rmid_req", processor_req, 0);
        chk("rmid_rd", mem_read_req, 0);
        chk("rmid_wr", mem_write_req, 0);
        chk("rmid_addr", addr, 0);
        chk("rmid_wdata", mem_write_data, 0);
        chk("rmid_rsp_valid", rsp_valid, 0);
        chk("rmid_ready", cmd_ready, 0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rpost_ready", cmd_ready, 1);
            chk("rpost_req", processor_req, 0);
            chk("rpost_rsp", rsp_valid, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
